// File: rtl/riscv_selftest_pkg.sv
// Shared types for the self-test sequencer: FSM state encoding and regfile address width.
package riscv_selftest_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/riscv_selftest_ctrl_sig.sv
// Signature accumulator: rotate-left-by-one then XOR the CPU PC, once per enabled cycle.
// Latency: one cycle per update. No backpressure; clr has priority over en.
module selftest_sig_acc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] sig
);

    logic [XLEN-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/riscv_selftest_ctrl.sv
// Self-test sequencer: load program into imem, run CPU until halt/timeout, verify NUM_CHK registers.
// Latency: N cycles to load N words, RUN bounded by TIMEOUT, CHECK at most NUM_CHK cycles.
// Backpressure: ld_ready high only in LOAD; SELFTEST_SIG_EN adds the PC signature port.
module riscv_selftest_ctrl
    import riscv_selftest_pkg::*;
#(
    parameter  int XLEN       = 32,
    parameter  int IMEM_DEPTH = 64,
    parameter  int NUM_CHK    = 4,
    parameter  int TIMEOUT    = 1024,
    parameter  int CYC_W      = 32,
    localparam int IAW        = $clog2(IMEM_DEPTH),
    localparam int FIW        = $clog2(NUM_CHK) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [XLEN-1:0]          ld_data,
    input  logic                     ld_last,
    output logic                     imem_we,
    output logic [IAW-1:0]           imem_waddr,
    output logic [XLEN-1:0]          imem_wdata,
    output logic                     cpu_rst,
    input  logic                     cpu_halt,
    input  logic [XLEN-1:0]          cpu_pc,
    input  logic [NUM_CHK*REG_AW-1:0] chk_reg,
    input  logic [NUM_CHK*XLEN-1:0]  chk_exp,
    output logic [REG_AW-1:0]        rf_raddr,
    input  logic [XLEN-1:0]          rf_rdata,
    output logic                     done,
    output logic                     pass,
    output logic                     tmo,
    output logic                     ld_ovf,
    output logic [FIW-1:0]           fail_idx,
    output logic [CYC_W-1:0]         cycles
`ifdef SELFTEST_SIG_EN
    ,
    output logic [XLEN-1:0]          sig
`endif
);

    localparam int SLOTS = 2 ** FIW;

    state_e            state_q, state_d;
    logic [IAW-1:0]    addr_q, addr_d;
    logic [FIW-1:0]    chk_idx_q, chk_idx_d;
    logic [FIW-1:0]    fail_idx_q, fail_idx_d;
    logic              pass_q, pass_d;
    logic              tmo_q, tmo_d;
    logic              ovf_q, ovf_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;

    // Check table padded to a power of two so the check index addresses it directly.
    logic [REG_AW-1:0] reg_arr [SLOTS];
    logic [XLEN-1:0]   exp_arr [SLOTS];

    for (genvar g = 0; g < SLOTS; g++) begin : g_chk
        if (g < NUM_CHK) begin : g_used
            assign reg_arr[g] = chk_reg[g*REG_AW +: REG_AW];
            assign exp_arr[g] = chk_exp[g*XLEN +: XLEN];
        end else begin : g_pad
            assign reg_arr[g] = '0;
            assign exp_arr[g] = '0;
        end
    end

    logic              start_ok;
    logic              ld_hs;
    logic [REG_AW-1:0] cur_reg;
    logic [XLEN-1:0]   cur_val;
    logic [CYC_W-1:0]  cyc_inc;

    assign start_ok = start && (state_q == IDLE || state_q == DONE);
    assign ld_hs    = ld_valid && (state_q == LOAD);
    assign cur_reg  = reg_arr[chk_idx_q];
    // x0 reads as zero regardless of what the debug port returns.
    assign cur_val  = (cur_reg == '0) ? '0 : rf_rdata;
    assign cyc_inc  = (&cycles_q) ? cycles_q : cycles_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        chk_idx_d  = chk_idx_q;
        fail_idx_d = fail_idx_q;
        pass_d     = pass_q;
        tmo_d      = tmo_q;
        ovf_d      = ovf_q;
        cycles_d   = cycles_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d    = LOAD;
                    addr_d     = '0;
                    chk_idx_d  = '0;
                    fail_idx_d = '1;
                    pass_d     = 1'b0;
                    tmo_d      = 1'b0;
                    ovf_d      = 1'b0;
                    cycles_d   = '0;
                end
            end
            LOAD: begin
                if (ld_hs) begin
                    addr_d = addr_q + 1'b1;
                    if (ld_last) begin
                        state_d = RUN;
                    end else if (addr_q == IAW'(IMEM_DEPTH - 1)) begin
                        ovf_d   = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cycles_d = cyc_inc;
                if (cpu_halt) begin
                    state_d   = CHECK;
                    chk_idx_d = '0;
                end else if (cyc_inc >= CYC_W'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    pass_d  = 1'b0;
                    state_d = DONE;
                end
            end
            CHECK: begin
                if (cur_val != exp_arr[chk_idx_q]) begin
                    fail_idx_d = chk_idx_q;
                    pass_d     = 1'b0;
                    state_d    = DONE;
                end else if (chk_idx_q == FIW'(NUM_CHK - 1)) begin
                    pass_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    chk_idx_d = chk_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            chk_idx_q  <= '0;
            fail_idx_q <= '1;
            pass_q     <= 1'b0;
            tmo_q      <= 1'b0;
            ovf_q      <= 1'b0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            chk_idx_q  <= chk_idx_d;
            fail_idx_q <= fail_idx_d;
            pass_q     <= pass_d;
            tmo_q      <= tmo_d;
            ovf_q      <= ovf_d;
            cycles_q   <= cycles_d;
        end
    end

    assign ld_ready   = (state_q == LOAD);
    assign imem_we    = ld_hs;
    assign imem_waddr = addr_q;
    assign imem_wdata = ld_data;
    assign cpu_rst    = !(state_q == RUN || state_q == CHECK);
    assign rf_raddr   = (state_q == CHECK) ? cur_reg : '0;
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign tmo        = tmo_q;
    assign ld_ovf     = ovf_q;
    assign fail_idx   = fail_idx_q;
    assign cycles     = cycles_q;

`ifdef SELFTEST_SIG_EN
    selftest_sig_acc #(.XLEN(XLEN)) u_sig (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .en    (state_q == RUN),
        .pc    (cpu_pc),
        .sig   (sig)
    );
`else
    logic unused_pc;
    assign unused_pc = ^cpu_pc;
`endif

endmodule

// File: tb/tb_riscv_selftest_ctrl.sv
// Directed bench for riscv_selftest_ctrl with a behavioural CPU/regfile stand-in.
module tb_riscv_selftest_ctrl;

    localparam int XLEN = 32;
    localparam int DEPTH = 8;
    localparam int NCHK = 2;
    localparam int TMO = 16;
    localparam int CYW = 32;
    localparam int IAW = $clog2(DEPTH);
    localparam int FIW = $clog2(NCHK) + 1;

    localparam logic [31:0] ADDI_X1 = 32'h00A00093;
    localparam logic [31:0] ADDI_X2 = 32'h00300113;
    localparam logic [31:0] EBREAK  = 32'h00100073;
    localparam logic [31:0] JAL_X0  = 32'h0000006F;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [XLEN-1:0]   ld_data = '0;
    logic              ld_last = 1'b0;
    logic              imem_we;
    logic [IAW-1:0]    imem_waddr;
    logic [XLEN-1:0]   imem_wdata;
    logic              cpu_rst;
    logic              cpu_halt;
    logic [XLEN-1:0]   cpu_pc;
    logic [NCHK*5-1:0] chk_reg = {5'd2, 5'd1};
    logic [NCHK*XLEN-1:0] chk_exp = {32'd3, 32'd10};
    logic [4:0]        rf_raddr;
    logic [XLEN-1:0]   rf_rdata;
    logic              done, pass, tmo, ld_ovf;
    logic [FIW-1:0]    fail_idx;
    logic [CYW-1:0]    cycles;
`ifdef SELFTEST_SIG_EN
    logic [XLEN-1:0]   sig;
`endif

    riscv_selftest_ctrl #(
        .XLEN(XLEN), .IMEM_DEPTH(DEPTH), .NUM_CHK(NCHK), .TIMEOUT(TMO), .CYC_W(CYW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .cpu_halt(cpu_halt), .cpu_pc(cpu_pc),
        .chk_reg(chk_reg), .chk_exp(chk_exp), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .done(done), .pass(pass), .tmo(tmo), .ld_ovf(ld_ovf),
        .fail_idx(fail_idx), .cycles(cycles)
`ifdef SELFTEST_SIG_EN
        , .sig(sig)
`endif
    );

    always #5 clk = ~clk;

    // CPU stand-in: halts on its halt_at-th cycle out of reset when halt_en is set.
    logic [31:0] rf [32];
    logic        halt_en = 1'b1;
    int          halt_at = 3;
    int          run_cnt = 0;
    int          wr_cnt = 0;
    int          low_cnt = 0;

    assign rf_rdata = rf[rf_raddr];
    assign cpu_halt = halt_en && !cpu_rst && (run_cnt == halt_at - 1);
    assign cpu_pc   = 32'(run_cnt) << 2;

    always @(posedge clk) begin
        if (imem_we) wr_cnt <= wr_cnt + 1;
        if (!cpu_rst) low_cnt <= low_cnt + 1;
        if (cpu_rst) run_cnt <= 0;
        else         run_cnt <= run_cnt + 1;
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks begin and end at a falling edge.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_word(input string tag, input logic [31:0] w, input logic last,
                             input logic [31:0] exp_addr);
        ld_valid = 1'b1;
        ld_data  = w;
        ld_last  = last;
        #1;
        chk({tag, " we"}, 32'(imem_we), 1);
        chk({tag, " waddr"}, 32'(imem_waddr), exp_addr);
        chk({tag, " wdata"}, imem_wdata, w);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done"}, 32'(done), 1);
    endtask

    task automatic load_prog1(input string tag);
        load_word({tag, " w0"}, ADDI_X1, 1'b0, 0);
        load_word({tag, " w1"}, ADDI_X2, 1'b0, 1);
        load_word({tag, " w2"}, EBREAK, 1'b1, 2);
    endtask

    int wr0, low0, n;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[1] = 32'd10;
        rf[2] = 32'd3;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst cpu_rst", 32'(cpu_rst), 1);
        chk("rst done", 32'(done), 0);
        chk("rst pass", 32'(pass), 0);
        chk("rst tmo", 32'(tmo), 0);
        chk("rst ld_ovf", 32'(ld_ovf), 0);
        chk("rst ld_ready", 32'(ld_ready), 0);
        chk("rst imem_we", 32'(imem_we), 0);
        chk("rst cycles", cycles, 0);
        chk("rst fail_idx", 32'(fail_idx), 3);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: passing program
        wr0 = wr_cnt; low0 = low_cnt;
        do_start();
        chk("t1 ld_ready", 32'(ld_ready), 1);
        load_prog1("t1");
        wait_done("t1");
        chk("t1 pass", 32'(pass), 1);
        chk("t1 tmo", 32'(tmo), 0);
        chk("t1 cycles", cycles, 3);
        chk("t1 fail_idx", 32'(fail_idx), 3);
        chk("t1 writes", 32'(wr_cnt - wr0), 3);
        chk("t1 cpu low cycles", 32'(low_cnt - low0), 5);
        chk("t1 cpu_rst in done", 32'(cpu_rst), 1);

        // 2: second check mismatches
        chk_exp = {32'd4, 32'd10};
        do_start();
        chk("t2 cleared done", 32'(done), 0);
        chk("t2 cleared pass", 32'(pass), 0);
        load_prog1("t2");
        n = 0;
        while (rf_raddr !== 5'd2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t2 check1 reached", 32'(rf_raddr), 2);
        chk("t2 done during check1", 32'(done), 0);
        @(negedge clk);
        chk("t2 done after check1", 32'(done), 1);
        chk("t2 pass", 32'(pass), 0);
        chk("t2 fail_idx", 32'(fail_idx), 1);
        chk("t2 cycles", cycles, 3);
        chk_exp = {32'd3, 32'd10};

        // 3: infinite loop times out; a start during RUN is ignored
        halt_en = 1'b0;
        do_start();
        low0 = low_cnt;
        load_word("t3 w0", JAL_X0, 1'b1, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t3 start ignored", 32'(cpu_rst), 0);
        wait_done("t3");
        chk("t3 tmo", 32'(tmo), 1);
        chk("t3 pass", 32'(pass), 0);
        chk("t3 cycles", cycles, 15);
        chk("t3 fail_idx", 32'(fail_idx), 3);
        chk("t3 no check cycles", 32'(low_cnt - low0), 15);
        halt_en = 1'b1;

        // 4: overflow, DEPTH+2 words without ld_last
        wr0 = wr_cnt;
        do_start();
        for (int k = 0; k < DEPTH + 2; k++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hA000_0000 + 32'(k);
            #1;
            if (k < DEPTH) begin
                chk("t4 we", 32'(imem_we), 1);
                chk("t4 waddr", 32'(imem_waddr), 32'(k));
            end else begin
                chk("t4 ld_ready after fill", 32'(ld_ready), 0);
                chk("t4 we after fill", 32'(imem_we), 0);
            end
            @(negedge clk);
        end
        ld_valid = 1'b0;
        chk("t4 writes", 32'(wr_cnt - wr0), DEPTH);
        wait_done("t4");
        chk("t4 ld_ovf", 32'(ld_ovf), 1);

        // 5: async reset mid-run, then rerun
        halt_at = 8;
        do_start();
        chk("t5 ld_ovf cleared", 32'(ld_ovf), 0);
        load_prog1("t5");
        n = 0;
        while (cycles !== 32'd5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5 reached cycle 5", cycles, 5);
        rst_n = 1'b0;
        #1;
        chk("t5 cpu_rst", 32'(cpu_rst), 1);
        chk("t5 done", 32'(done), 0);
        chk("t5 pass", 32'(pass), 0);
        chk("t5 tmo", 32'(tmo), 0);
        chk("t5 cycles", cycles, 0);
        chk("t5 ld_ready", 32'(ld_ready), 0);
        chk("t5 fail_idx", 32'(fail_idx), 3);
        @(negedge clk);
        rst_n = 1'b1;
        halt_at = 3;
        @(negedge clk);
        do_start();
        load_prog1("t5r");
        wait_done("t5r");
        chk("t5r pass", 32'(pass), 1);
        chk("t5r cycles", cycles, 3);

        // 6: ld_valid toggling
        wr0 = wr_cnt;
        do_start();
        load_word("t6 w0", ADDI_X1, 1'b0, 0);
        #1 chk("t6 gap0 we", 32'(imem_we), 0);
        chk("t6 gap0 ready", 32'(ld_ready), 1);
        @(negedge clk);
        load_word("t6 w1", ADDI_X2, 1'b0, 1);
        #1 chk("t6 gap1 we", 32'(imem_we), 0);
        @(negedge clk);
        load_word("t6 w2", EBREAK, 1'b1, 2);
        chk("t6 writes", 32'(wr_cnt - wr0), 3);
        wait_done("t6");
        chk("t6 pass", 32'(pass), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
